// File: rtl/dec_scan_pkg.sv
// Shared definitions for the dec_scan select decoder: mode encodings and FSM states.
package dec_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/dec_onehot.sv
// Combinational index -> one-hot line decode with enable and selectable polarity.
module dec_onehot #(
  parameter int N          = 3,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [N-1:0]      idx,
  input  logic              en,
  output logic [2**N-1:0]   lines
);

  logic [2**N-1:0] hot;

  // Raise the selected line when enabled, then apply output polarity.
  always_comb begin
    hot = '0;
    if (en) begin
      hot[idx] = 1'b1;
    end
    lines = (ACTIVE_LOW != 0) ? ~hot : hot;
  end

endmodule

// File: rtl/dec_scan.sv
// Registered N-to-2^N select decoder with DIRECT (hold loaded address) and
// SCAN (walk every line for DWELL cycles, pulse wrap on rollover) modes.
module dec_scan
  import dec_scan_pkg::*;
#(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      a,
  input  logic              a_valid,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int L  = 2**N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
  localparam logic [L-1:0]  Y_IDLE  = (ACTIVE_LOW != 0) ? {L{1'b1}} : {L{1'b0}};

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;
  logic [L-1:0]    y_q, y_d;

  // Next state, index, dwell count and wrap flag. The inputs of the current
  // cycle pick the next state; the cycle that enters SCAN shows the held
  // position without advancing, so every line is lit for exactly DWELL cycles
  // and a pause via en resumes mid-dwell where it stopped.
  always_comb begin
    state_d = ST_IDLE;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (mode == MODE_SCAN) begin
        state_d = ST_SCAN;
        if (a_valid) begin
          idx_d = a;
          cnt_d = '0;
        end else if (state_q == ST_DIRECT) begin
          cnt_d = '0;
        end else if (state_q == ST_SCAN) begin
          if (cnt_q == CNT_MAX) begin
            idx_d  = idx_q + N'(1);
            cnt_d  = '0;
            wrap_d = (idx_q == {N{1'b1}});
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end else begin
        state_d = ST_DIRECT;
        cnt_d   = '0;
        if (a_valid) begin
          idx_d = a;
        end
      end
    end
  end

  // Decode the next index so y and idx change on the same edge.
  dec_onehot #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_onehot (
    .idx   (idx_d),
    .en    (en),
    .lines (y_d)
  );

  // State, position and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      y_q     <= Y_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed bench for dec_scan: one N=3/DWELL=4 active-high instance and one
// N=2/DWELL=1 active-low instance sharing clock and reset.
`timescale 1ns/1ps
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, a_valid;
  logic [2:0] a;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  logic       en2, mode2, a_valid2;
  logic [1:0] a2;
  logic [3:0] y2;
  logic [1:0] idx2;
  logic       wrap2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_scan #(.N(3), .DWELL(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .a_valid(a_valid),
    .y(y), .idx(idx), .wrap(wrap)
  );

  dec_scan #(.N(2), .DWELL(1), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .a(a2), .a_valid(a_valid2),
    .y(y2), .idx(idx2), .wrap(wrap2)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; a = '0; a_valid = 1'b0;
    en2 = 1'b0; mode2 = 1'b0; a2 = '0; a_valid2 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b1; a = 3'd0; a_valid = 1'b0;
    en2 = 1'b1; mode2 = 1'b1; a2 = '0; a_valid2 = 1'b0;
    step(); step(); step();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", y); end
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (y2 !== 4'hF) begin errors++; $display("FAIL reset_y_al got=%h exp=f", y2); end
    #2 rst = 1'b0;
    #1;
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_rel_y got=%h exp=00", y); end
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL reset_rel_idx got=%0d exp=0", idx); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_rel_wrap got=%b exp=0", wrap); end
    en = 1'b0; en2 = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    en = 1'b1; mode = 1'b0; a = 3'd5; a_valid = 1'b1;
    step();
    a_valid = 1'b0; a = 3'd3;
    checks++; if (y !== 8'h20) begin errors++; $display("FAIL direct_load_y got=%h exp=20", y); end
    checks++; if (idx !== 3'd5) begin errors++; $display("FAIL direct_load_idx got=%0d exp=5", idx); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (y !== 8'h20 || idx !== 3'd5 || wrap !== 1'b0) begin
        errors++; $display("FAIL direct_hold c%0d got y=%h idx=%0d wrap=%b exp y=20 idx=5 wrap=0", i, y, idx, wrap);
      end
    end
    en = 1'b0;
    step();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL direct_off_y got=%h exp=00", y); end
    checks++; if (idx !== 3'd5) begin errors++; $display("FAIL direct_off_idx got=%0d exp=5", idx); end
  endtask

  task automatic test_scan();
    logic [2:0] exp_idx;
    logic [7:0] exp_y;
    logic       exp_wrap;
    do_reset();
    en = 1'b1; mode = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      exp_idx  = 3'((k - 1) / 4);
      exp_y    = 8'h01 << exp_idx;
      exp_wrap = (k > 1) && (((k - 1) % 32) == 0);
      checks++; if (y !== exp_y) begin errors++; $display("FAIL scan_y k%0d got=%h exp=%h", k, y, exp_y); end
      checks++; if (idx !== exp_idx) begin errors++; $display("FAIL scan_idx k%0d got=%0d exp=%0d", k, idx, exp_idx); end
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL scan_wrap k%0d got=%b exp=%b", k, wrap, exp_wrap); end
    end
  endtask

  task automatic test_scan_reload();
    do_reset();
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 26; k++) step();
    checks++; if (idx !== 3'd6) begin errors++; $display("FAIL reload_pre_idx got=%0d exp=6", idx); end
    a = 3'd2; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    checks++; if (y !== 8'h04 || idx !== 3'd2 || wrap !== 1'b0) begin
      errors++; $display("FAIL reload_load got y=%h idx=%0d wrap=%b exp y=04 idx=2 wrap=0", y, idx, wrap);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (y !== 8'h04 || wrap !== 1'b0) begin
        errors++; $display("FAIL reload_dwell c%0d got y=%h wrap=%b exp y=04 wrap=0", i, y, wrap);
      end
    end
    step();
    checks++; if (y !== 8'h08) begin errors++; $display("FAIL reload_next got=%h exp=08", y); end
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (y !== 8'h00 || idx !== 3'd3) begin
        errors++; $display("FAIL pause c%0d got y=%h idx=%0d exp y=00 idx=3", i, y, idx);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (y !== 8'h08 || idx !== 3'd3) begin
        errors++; $display("FAIL resume c%0d got y=%h idx=%0d exp y=08 idx=3", i, y, idx);
      end
    end
    step();
    checks++; if (y !== 8'h10 || idx !== 3'd4) begin
      errors++; $display("FAIL resume_adv got y=%h idx=%0d exp y=10 idx=4", y, idx);
    end
  endtask

  task automatic test_active_low();
    logic [3:0] exp_tbl [4];
    exp_tbl[0] = 4'b1110; exp_tbl[1] = 4'b1101; exp_tbl[2] = 4'b1011; exp_tbl[3] = 4'b0111;
    do_reset();
    checks++; if (y2 !== 4'b1111) begin errors++; $display("FAIL al_idle got=%b exp=1111", y2); end
    en2 = 1'b1; mode2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++; if (y2 !== exp_tbl[k % 4]) begin
        errors++; $display("FAIL al_walk k%0d got=%b exp=%b", k, y2, exp_tbl[k % 4]);
      end
      checks++; if (wrap2 !== (k == 4 || k == 8)) begin
        errors++; $display("FAIL al_wrap k%0d got=%b exp=%b", k, wrap2, (k == 4 || k == 8));
      end
    end
    en2 = 1'b0;
    step();
    checks++; if (y2 !== 4'b1111) begin errors++; $display("FAIL al_off got=%b exp=1111", y2); end
  endtask

  task automatic test_async_and_mode();
    do_reset();
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 32; k++) step();
    checks++; if (idx !== 3'd7) begin errors++; $display("FAIL async_pre_idx got=%0d exp=7", idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (y !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL async_now got y=%h idx=%0d wrap=%b exp y=00 idx=0 wrap=0", y, idx, wrap);
    end
    step();
    checks++; if (y !== 8'h00 || wrap !== 1'b0) begin
      errors++; $display("FAIL async_hold got y=%h wrap=%b exp y=00 wrap=0", y, wrap);
    end
    #2 rst = 1'b0;
    step();
    checks++; if (y !== 8'h01 || idx !== 3'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL async_restart got y=%h idx=%0d wrap=%b exp y=01 idx=0 wrap=0", y, idx, wrap);
    end
    step(); step();
    mode = 1'b0;
    step();
    checks++; if (y !== 8'h01 || idx !== 3'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL to_direct got y=%h idx=%0d wrap=%b exp y=01 idx=0 wrap=0", y, idx, wrap);
    end
    step();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (y !== 8'h01) begin errors++; $display("FAIL to_scan_dwell c%0d got=%h exp=01", i, y); end
    end
    step();
    checks++; if (y !== 8'h02 || idx !== 3'd1) begin
      errors++; $display("FAIL to_scan_adv got y=%h idx=%0d exp y=02 idx=1", y, idx);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_scan_reload();
    test_active_low();
    test_async_and_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
